// File: rtl/idecode_if.sv
// Bus bundle between the fetch/writeback side and the instruction decoder.
// master : drives the fetched instruction, pipeline controls and the
//          writeback port, and observes the ID/EX register outputs.
// slave  : the decoder itself.
// Signals:
//   IR_in, NPC_in, valid_in : fetched instruction, next PC, real-instruction flag
//   stall, flush            : hold / bubble the ID/EX register
//   wb_en, wb_addr, wb_data : register bank write port from writeback
//   A, B, Imm, NPC, IR      : latched operands, immediate, PC and instruction
//   itype, valid, halted    : instruction class, real-instruction flag, halt state
interface idecode_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [DW-1:0] IR_in;
    logic [DW-1:0] NPC_in;
    logic          valid_in;
    logic          stall;
    logic          flush;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [DW-1:0] Imm;
    logic [DW-1:0] NPC;
    logic [DW-1:0] IR;
    logic [2:0]    itype;
    logic          valid;
    logic          halted;

    modport master (
        output IR_in, NPC_in, valid_in, stall, flush, wb_en, wb_addr, wb_data,
        input  A, B, Imm, NPC, IR, itype, valid, halted
    );

    modport slave (
        input  IR_in, NPC_in, valid_in, stall, flush, wb_en, wb_addr, wb_data,
        output A, B, Imm, NPC, IR, itype, valid, halted
    );
endinterface

// File: rtl/idecode.sv
// MIPS32 instruction decode stage.
// Reads rs/rt from a 32-entry register bank (with write-through bypass from
// writeback), sign-extends the 16-bit immediate, classifies the opcode and
// latches everything into the ID/EX register one cycle later. A two-state
// machine (RUN/HALTED) freezes the stage after a HLT is decoded.
// Ports:
//   clk   : pipeline clock
//   rst_n : synchronous active-low reset (clears ID/EX, register bank, FSM)
//   bus   : idecode_if slave modport (inputs from fetch/writeback, ID/EX outputs)
module idecode #(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic clk,
    input  logic rst_n,
    idecode_if.slave bus
);
    localparam int AW = $clog2(NREG);

    localparam logic [2:0] IT_RR      = 3'd0;
    localparam logic [2:0] IT_RM      = 3'd1;
    localparam logic [2:0] IT_LOAD    = 3'd2;
    localparam logic [2:0] IT_STORE   = 3'd3;
    localparam logic [2:0] IT_BRANCH  = 3'd4;
    localparam logic [2:0] IT_HALT    = 3'd5;
    localparam logic [2:0] IT_INVALID = 3'd7;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t        state_reg;
    logic [DW-1:0] a_reg, b_reg, imm_reg, npc_reg, ir_reg;
    logic [2:0]    itype_reg;
    logic          valid_reg, halted_reg;

    logic [DW-1:0] reg_file [NREG];
    logic [DW-1:0] a_next, b_next, imm_next;
    logic [2:0]    itype_next;
    logic [AW-1:0] rs_addr, rt_addr;

    function automatic logic [2:0] classify(input logic [5:0] op);
        case (op)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: classify = IT_RR;
            6'd10, 6'd11, 6'd12:                classify = IT_RM;
            6'd8:                               classify = IT_LOAD;
            6'd9:                               classify = IT_STORE;
            6'd13, 6'd14:                       classify = IT_BRANCH;
            6'd63:                              classify = IT_HALT;
            default:                            classify = IT_INVALID;
        endcase
    endfunction

    // Register bank: entry 0 is hard-wired to zero, every other entry is its
    // own register so reset can clear the whole bank in a single cycle.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign reg_file[gi] = '0;
            end else begin : g_word
                logic [DW-1:0] word_reg;
                always_ff @(posedge clk) begin
                    if (!rst_n)
                        word_reg <= '0;
                    else if (bus.wb_en && bus.wb_addr == AW'(gi))
                        word_reg <= bus.wb_data;
                end
                assign reg_file[gi] = word_reg;
            end
        end
    endgenerate

    assign rs_addr = bus.IR_in[21 +: AW];
    assign rt_addr = bus.IR_in[16 +: AW];

    // Operand read with bypass: a same-cycle writeback to the address being
    // read is forwarded so the value latched into ID/EX is never stale.
    always_comb begin
        a_next = '0;
        b_next = '0;
        if (rs_addr != '0)
            a_next = (bus.wb_en && bus.wb_addr == rs_addr) ? bus.wb_data : reg_file[rs_addr];
        if (rt_addr != '0)
            b_next = (bus.wb_en && bus.wb_addr == rt_addr) ? bus.wb_data : reg_file[rt_addr];
        imm_next   = {{(DW-16){bus.IR_in[15]}}, bus.IR_in[15:0]};
        itype_next = classify(bus.IR_in[31:26]);
    end

    // ID/EX register and halt state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_RUN;
            a_reg      <= '0;
            b_reg      <= '0;
            imm_reg    <= '0;
            npc_reg    <= '0;
            ir_reg     <= '0;
            itype_reg  <= '0;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_HALTED: begin
                    // Drop the HLT's valid once; everything else stays frozen.
                    valid_reg <= 1'b0;
                end
                default: begin
                    if (bus.flush) begin
                        a_reg     <= '0;
                        b_reg     <= '0;
                        imm_reg   <= '0;
                        npc_reg   <= '0;
                        ir_reg    <= '0;
                        itype_reg <= '0;
                        valid_reg <= 1'b0;
                    end else if (!bus.stall) begin
                        a_reg     <= a_next;
                        b_reg     <= b_next;
                        imm_reg   <= imm_next;
                        npc_reg   <= bus.NPC_in;
                        ir_reg    <= bus.IR_in;
                        itype_reg <= itype_next;
                        valid_reg <= bus.valid_in && (itype_next != IT_INVALID);
                        if (bus.valid_in && itype_next == IT_HALT) begin
                            state_reg  <= ST_HALTED;
                            halted_reg <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.A      = a_reg;
    assign bus.B      = b_reg;
    assign bus.Imm    = imm_reg;
    assign bus.NPC    = npc_reg;
    assign bus.IR     = ir_reg;
    assign bus.itype  = itype_reg;
    assign bus.valid  = valid_reg;
    assign bus.halted = halted_reg;
endmodule

// File: tb/tb_idecode.sv
// Randomized + directed scoreboard bench for idecode. The stimulus process
// drives one transaction per cycle, runs a behavioural decode model and
// pushes the expected ID/EX state; a monitor pops and compares after each edge.
module tb_idecode;
    typedef struct packed {
        logic [31:0] A;
        logic [31:0] B;
        logic [31:0] Imm;
        logic [31:0] NPC;
        logic [31:0] IR;
        logic [2:0]  itype;
        logic        valid;
        logic        halted;
    } out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    idecode_if #(.DW(32), .AW(5)) bus_if ();
    idecode #(.DW(32), .NREG(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    int total = 0;
    int bad = 0;

    out_t  exp_q [$];
    string tag_q [$];

    // Reference model state
    logic [31:0] m_regs [32];
    out_t        m_out;
    bit          m_halted;

    function automatic int class_of(int op);
        if (op >= 0 && op <= 5)   return 0;
        if (op >= 10 && op <= 12) return 1;
        if (op == 8)              return 2;
        if (op == 9)              return 3;
        if (op == 13 || op == 14) return 4;
        if (op == 63)             return 5;
        return 7;
    endfunction

    function automatic logic [31:0] rd(int r, logic wen, logic [4:0] wa, logic [31:0] wd);
        if (r == 0) return 32'h0;
        if (wen && int'(wa) == r) return wd;
        return m_regs[r];
    endfunction

    task automatic step(input string tag, input logic rstn, input logic [31:0] ir,
                        input logic [31:0] npc, input logic vin, input logic stl,
                        input logic fl, input logic wen, input logic [4:0] wa,
                        input logic [31:0] wd);
        int cls;
        @(negedge clk);
        rst_n           = rstn;
        bus_if.IR_in    = ir;
        bus_if.NPC_in   = npc;
        bus_if.valid_in = vin;
        bus_if.stall    = stl;
        bus_if.flush    = fl;
        bus_if.wb_en    = wen;
        bus_if.wb_addr  = wa;
        bus_if.wb_data  = wd;
        if (!rstn) begin
            m_out    = '0;
            m_halted = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else begin
            if (m_halted) begin
                m_out.valid = 1'b0;
            end else if (fl) begin
                m_out = '0;
            end else if (!stl) begin
                cls         = class_of(int'(ir[31:26]));
                m_out.A     = rd(int'(ir[25:21]), wen, wa, wd);
                m_out.B     = rd(int'(ir[20:16]), wen, wa, wd);
                m_out.Imm   = 32'(signed'(ir[15:0]));
                m_out.NPC   = npc;
                m_out.IR    = ir;
                m_out.itype = 3'(cls);
                m_out.valid = vin && (cls != 7);
                if (vin && cls == 5) m_halted = 1;
            end
            m_out.halted = m_halted;
            if (wen && wa != 5'd0) m_regs[wa] = wd;
        end
        exp_q.push_back(m_out);
        tag_q.push_back(tag);
    endtask

    // Monitor: the decoder presents a new ID/EX state every cycle.
    initial begin
        out_t  got, e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                got.A      = bus_if.A;
                got.B      = bus_if.B;
                got.Imm    = bus_if.Imm;
                got.NPC    = bus_if.NPC;
                got.IR     = bus_if.IR;
                got.itype  = bus_if.itype;
                got.valid  = bus_if.valid;
                got.halted = bus_if.halted;
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s got A=%h B=%h Imm=%h NPC=%h IR=%h it=%0d v=%b h=%b want A=%h B=%h Imm=%h NPC=%h IR=%h it=%0d v=%b h=%b",
                             t, got.A, got.B, got.Imm, got.NPC, got.IR, got.itype, got.valid, got.halted,
                             e.A, e.B, e.Imm, e.NPC, e.IR, e.itype, e.valid, e.halted);
                end else begin
                    $display("txn %0d %s ok IR=%h it=%0d v=%b h=%b", total, t, got.IR, got.itype, got.valid, got.halted);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int opl [13] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14};
        logic [31:0] ir;
        logic [5:0]  op;
        bus_if.IR_in = '0; bus_if.NPC_in = '0; bus_if.valid_in = 0;
        bus_if.stall = 0; bus_if.flush = 0; bus_if.wb_en = 0;
        bus_if.wb_addr = '0; bus_if.wb_data = '0;
        m_out = '0; m_halted = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

        // Reset with random inputs, write attempts must be dropped
        for (int i = 0; i < 2; i++)
            step("reset", 1'b0, $urandom, $urandom, 1'b1, 1'($urandom), 1'($urandom),
                 1'b1, 5'($urandom_range(1, 31)), $urandom);

        // Every register reads zero after reset
        for (int r = 0; r < 32; r += 2)
            step("rd_zero", 1'b1, {6'd0, 5'(r), 5'(r + 1), 16'h0}, 32'h100 + 32'(r), 1'b1,
                 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        // Write-through bypass, then the stored value
        step("bypass", 1'b1, 32'h00A0_0000, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        step("rd_r5", 1'b1, 32'h00A0_0000, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        // R0 writes are discarded
        step("wr_r0", 1'b1, 32'h0000_0000, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234);
        step("rd_r0", 1'b1, 32'h0000_0000, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        // Immediate extension and classes
        step("addi", 1'b1, 32'h2822_FFFC, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step("lw", 1'b1, 32'h20A3_0010, 32'h18, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step("sw", 1'b1, 32'h24A3_8000, 32'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step("invalid", 1'b1, 32'h5400_0000, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        // Stall holds, flush beats stall
        step("npc40", 1'b1, 32'h0043_0001, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++)
            step("stall", 1'b1, $urandom, 32'h44 + 32'(4 * i), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step("flush_stall", 1'b1, 32'h0043_0001, 32'h50, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);

        // Ifetch-style stream: 10 clean pairs, then mixed stall/flush/writeback
        for (int i = 0; i < 40; i++) begin
            int k = $urandom_range(0, 15);
            op = (k < 13) ? 6'(opl[k]) : 6'($urandom_range(0, 62));
            ir = {op, 26'($urandom)};
            if (i < 10)
                step("stream", 1'b1, ir, $urandom, 1'b1, 1'b0, 1'b0,
                     1'($urandom), 5'($urandom), $urandom);
            else
                step("mixed", 1'b1, ir, $urandom, 1'($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                     1'($urandom), 5'($urandom), $urandom);
        end

        // Halt: entry, freeze for 5 cycles, writeback still lands
        step("hlt", 1'b1, 32'hFC00_0000, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i == 3)
                step("halted_wb", 1'b1, $urandom, $urandom, 1'b1, 1'($urandom), 1'($urandom),
                     1'b1, 5'd7, 32'hCAFE_0007);
            else
                step("halted", 1'b1, $urandom, $urandom, 1'b1, 1'($urandom), 1'($urandom),
                     1'b0, 5'd0, 32'h0);
            if (i == 4) begin
                total++;
                if (u_dut.reg_file[7] !== m_regs[7]) begin
                    bad++;
                    $display("FAIL halted_r7 got %h want %h", u_dut.reg_file[7], m_regs[7]);
                end else begin
                    $display("txn %0d halted_r7 ok %h", total, m_regs[7]);
                end
            end
        end

        // Reset out of HALTED, then decode resumes
        step("reset_halt", 1'b0, 32'hFC00_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step("after_rst", 1'b1, 32'h28E7_0003, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step("beqz", 1'b1, 32'h38E0_FFFE, 32'h304, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
